// File: rtl/mux_sel_if.sv
// mux_sel_if: request/grant/select bundle between the two sources and the sequencer
// master: source side (drives req_a, req_b and, with SEL_LOCK_EN, lock)
// slave: sequencer side (drives sel, grant_a, grant_b, sw, busy)
interface mux_sel_if;
  logic req_a, req_b, sel, grant_a, grant_b, sw, busy;
`ifdef SEL_LOCK_EN
  logic lock;
  modport master(output req_a, req_b, lock, input sel, grant_a, grant_b, sw, busy);
  modport slave(input req_a, req_b, lock, output sel, grant_a, grant_b, sw, busy);
`else
  modport master(output req_a, req_b, input sel, grant_a, grant_b, sw, busy);
  modport slave(input req_a, req_b, output sel, grant_a, grant_b, sw, busy);
`endif
endinterface

// File: rtl/mux_sel_sequencer.sv
// mux_sel_sequencer: round-robin 2:1 mux select sequencer with dwell time and break-before-make guard
// clk, rst_n (async active-low); bus.req_a/req_b in; bus.sel, grant_a, grant_b, sw, busy out.
// SEL_LOCK_EN adds bus.lock: holds the current grant past dwell expiry while its request stays high.
module mux_sel_sequencer #(
  parameter int DWELL = 4,
  parameter int CW = 8
) (
  input logic clk,
  input logic rst_n,
  mux_sel_if.slave bus
);
  typedef enum logic [1:0] {IDLE, GNT_A, GNT_B, GUARD} state_t;
  localparam int D = DWELL < 1 ? 1 : DWELL;
  localparam logic [CW-1:0] LIM = CW'(D - 1);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic sel, sel_n, sw, sw_n, last, last_n, nxt, nxt_n, enter, tgt, own, req_own, req_oth, lock;
`ifdef SEL_LOCK_EN
  assign lock = bus.lock;
`else
  assign lock = 1'b0;
`endif
  assign own = state == GNT_B;
  assign req_own = own ? bus.req_b : bus.req_a;
  assign req_oth = own ? bus.req_a : bus.req_b;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    sel_n = sel;
    sw_n = 1'b0;
    last_n = last;
    nxt_n = nxt;
    enter = 1'b0;
    tgt = 1'b0;
    case (state)
      IDLE: begin
        enter = bus.req_a | bus.req_b;
        tgt = !(bus.req_a & (!bus.req_b | last));
      end
      GUARD: begin
        state_n = IDLE;
        enter = bus.req_a | bus.req_b;
        tgt = (nxt ? bus.req_b : bus.req_a) ? nxt : !nxt;
      end
      default: begin
        cnt_n = cnt + 1'b1;
        if (!req_own) begin
          state_n = GUARD;
          nxt_n = !own;
        end else if (cnt == LIM && lock) cnt_n = cnt;
        else if (cnt == LIM && req_oth) begin
          state_n = GUARD;
          nxt_n = !own;
        end else if (cnt == LIM) cnt_n = '0;
      end
    endcase
    if (enter) begin
      state_n = tgt ? GNT_B : GNT_A;
      sel_n = tgt;
      sw_n = 1'b1;
      cnt_n = '0;
      last_n = tgt;
    end
    if (state_n == GUARD) sel_n = nxt_n;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      sel <= 1'b0;
      sw <= 1'b0;
      last <= 1'b1;
      nxt <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      sel <= sel_n;
      sw <= sw_n;
      last <= last_n;
      nxt <= nxt_n;
    end
  assign bus.sel = sel;
  assign bus.sw = sw;
  assign bus.grant_a = state == GNT_A;
  assign bus.grant_b = state == GNT_B;
  assign bus.busy = state != IDLE;
endmodule
